// File: rtl/pedal_pkg.sv
// pedal_pkg: shared button indices, debounce FSM states and tick ratio for the button conditioner
package pedal_pkg;
  localparam int BTN_L = 2;
  localparam int BTN_C = 1;
  localparam int BTN_R = 0;
  localparam int TICK_RATIO = 8;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus stability-window FSM for one button
module btn_debounce
  import pedal_pkg::*;
#(
  parameter int DB_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam int CW = $clog2(DB_CYCLES);
  logic [1:0] sync;
  logic synced;
  logic [CW-1:0] cnt, cnt_d;
  logic level_d, pulse_d, done;
  db_state_t state, state_d;
  assign synced = sync[1];
  assign done = cnt == CW'(DB_CYCLES - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      sync <= '0;
      state <= IDLE;
      cnt <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      state <= state_d;
      cnt <= cnt_d;
      level <= level_d;
      pulse <= pulse_d;
    end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    level_d = level;
    pulse_d = 1'b0;
    case (state)
      IDLE:
        if (synced) begin
          state_d = PRESS_WAIT;
          cnt_d = '0;
        end
      PRESS_WAIT:
        if (!synced) state_d = IDLE;
        else if (done) begin
          state_d = PRESSED;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else cnt_d = cnt + CW'(1);
      PRESSED:
        if (!synced) begin
          state_d = RELEASE_WAIT;
          cnt_d = '0;
        end
      RELEASE_WAIT:
        if (synced) state_d = PRESSED;
        else if (done) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else cnt_d = cnt + CW'(1);
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces three buttons and generates phase-aligned 12 Hz / 1.5 Hz rate strobes
module button_conditioner
  import pedal_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] butn_raw,
  output logic [2:0] butn_out,
  output logic [2:0] press_pulse,
  output logic       tick_12hz,
  output logic       tick_1hz5
);
  localparam int DB_RAW = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int DB_CYCLES = DB_RAW < 2 ? 2 : DB_RAW;
  localparam int TICK_DIV = CLK_HZ / 12;
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int RW = $clog2(TICK_RATIO);
  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] ratio_cnt;
  logic wrap;
  for (genvar g = 0; g < 3; g++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk(clk),
      .rst_n(rst_n),
      .raw(butn_raw[g]),
      .level(butn_out[g]),
      .pulse(press_pulse[g])
    );
  end
  assign wrap = tick_cnt == TW'(TICK_DIV - 1);
  // the slow strobe is derived from the fast wrap so both stay phase-aligned
  always_ff @(posedge clk)
    if (!rst_n) begin
      tick_cnt <= '0;
      ratio_cnt <= '0;
      tick_12hz <= 1'b0;
      tick_1hz5 <= 1'b0;
    end else begin
      tick_cnt <= wrap ? '0 : tick_cnt + TW'(1);
      ratio_cnt <= wrap ? ratio_cnt + RW'(1) : ratio_cnt;
      tick_12hz <= wrap;
      tick_1hz5 <= wrap && ratio_cnt == RW'(TICK_RATIO - 1);
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 10, debounce stability window in ms.
REQ-003 Port clk  input  1  system clock; the only clock in the block.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port butn_raw  input  3  raw asynchronous buttons, left to right: [2]=L, [1]=C, [0]=R.
REQ-006 Port butn_out  output  3  debounced button levels, same bit order as butn_raw.
REQ-007 Port press_pulse  output  3  one-cycle strobe per button on each debounced press.
REQ-008 Port tick_12hz  output  1  one-cycle strobe at 12 Hz, used downstream as the effect-scroll rate enable.
REQ-009 Port tick_1hz5  output  1  one-cycle strobe at 1.5 Hz, used downstream as the mode-toggle rate enable.

Function
REQ-010 Each butn_raw bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 DB_CYCLES SHALL equal CLK_HZ/1000*DEBOUNCE_MS, in integer arithmetic, and SHALL be at least 2; the counter width SHALL be $clog2(DB_CYCLES).
REQ-012 Each button SHALL have an independent FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-013 IDLE, synced=1: go to PRESS_WAIT, cnt=0.
REQ-014 PRESS_WAIT, synced=0: go to IDLE (glitch rejected).
REQ-015 PRESS_WAIT, synced=1, cnt==DB_CYCLES-1: go to PRESSED, set butn_out=1, and pulse press_pulse for 1 cycle.
REQ-016 PRESS_WAIT, synced=1, otherwise: cnt increments.
REQ-017 PRESSED, synced=0: go to RELEASE_WAIT, cnt=0.
REQ-018 RELEASE_WAIT, synced=1: go to PRESSED (bounce rejected; butn_out stays 1; no new pulse).
REQ-019 RELEASE_WAIT, synced=0, cnt==DB_CYCLES-1: go to IDLE and clear butn_out; else cnt increments.
REQ-020 Latency: butn_out SHALL rise on rising edge number DB_CYCLES+3, counting as edge 1 the edge that first samples butn_raw high, provided butn_raw stays high throughout; release SHALL be symmetric.
REQ-021 press_pulse SHALL be high only in the first cycle in which butn_out is high; holding a button SHALL never repeat the pulse.
REQ-022 Buttons SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses with no priority or masking.
REQ-023 TICK_DIV SHALL equal CLK_HZ/12; a free-running counter SHALL assert tick_12hz for 1 cycle when it reaches TICK_DIV-1, then wrap to 0.
REQ-024 tick_1hz5 SHALL assert in the same cycle as every 8th tick_12hz, using a 3-bit wrap counter; the two ticks SHALL stay phase-aligned.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 When rst_n=0 at a clk edge, all of the following SHALL clear to 0 on that edge regardless of state: synchronizers, FSMs (to IDLE), cnt, tick counters, butn_out, press_pulse, tick_12hz and tick_1hz5.
REQ-027 After reset release, the first tick_12hz SHALL occur TICK_DIV cycles later, and the first tick_1hz5 SHALL occur 8*TICK_DIV cycles later.
REQ-028 A reset mid-debounce SHALL discard the partial count; a button held through reset SHALL require a full DB_CYCLES window after release of reset.

Structure
REQ-029 Package pedal_pkg SHALL hold: BTN_L=2, BTN_C=1 and BTN_R=0; enum db_state_t {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT}; and the tick ratio constant TICK_RATIO=8.
REQ-030 Sub-module btn_debounce SHALL contain the synchronizer, FSM and counter for one button, and SHALL be instantiated 3 times.
REQ-031 The tick generator SHALL reside in the top level.

Verification (CLK_HZ=12000, DEBOUNCE_MS=1, so DB_CYCLES=12 and TICK_DIV=1000)
REQ-032 Scenario: hold butn_raw=3'b001 -> butn_out[0] rises on edge 15, press_pulse=3'b001 for exactly 1 cycle, and no further pulse over 100 cycles.
REQ-033 Scenario: butn_raw[2] high for 8 cycles then low -> butn_out and press_pulse remain 0.
REQ-034 Scenario: C pressed and stable, then a release bouncing 0/1 every 5 cycles for 40 cycles, then low -> butn_out[1] stays 1 during the bounce, falls 15 cycles after the final fall, and no extra pulse occurs.
REQ-035 Scenario: L and R raised on the same edge -> press_pulse=3'b101 in a single cycle.
REQ-036 Scenario: free run for 16000 cycles after reset -> tick_12hz at cycles 1000, 2000, ..., and tick_1hz5 only at cycles 8000 and 16000, coincident with tick_12hz.
REQ-037 Scenario: rst_n pulsed low at cnt=6 while C is held -> all outputs 0 on the next edge, and butn_out[1] rises 15 edges after rst_n returns high.
